// File: rtl/multi_round_game_controller.sv
// multi_round_game_controller
//   Turn/round sequencer for the mental-math binary game. Runs NUM_ROUNDS
//   rounds of one timed turn per player, keeps saturating per-player scores
//   and reports the winner (highest score, lowest index on tie). Load and RNG
//   strobes from the entry logic only pass through while a turn is live.
// Ports
//   clk, rst                    clock, asynchronous active-high reset
//   passed, start, abort        unlock level, start/continue level, sync abort
//   load_in, rng_gen_in         entry-logic strobes (only honoured in PLAY)
//   time_out                    digit timer expired
//   answer_valid/answer_correct answer submitted / answer was right
//   load_out, rng_gen_out       gated strobes
//   timer_enable/timer_reconfig timer run level / one-cycle reload pulse
//   active_player, round_idx    whose turn, which round (0-based)
//   scores                      player p at [p*SCORE_W +: SCORE_W]
//   game_over, winner           end-of-game flag and winning player

// One player's score register; saturates instead of wrapping.
module mrgc_score_slot #(
    parameter int SCORE_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clr,
    input  logic               inc,
    output logic [SCORE_W-1:0] score
);
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            score <= '0;
        else if (clr)
            score <= '0;
        else if (inc && (score != {SCORE_W{1'b1}}))
            score <= score + 1'b1;
    end
endmodule

module multi_round_game_controller #(
    parameter int NUM_PLAYERS = 2,
    parameter int NUM_ROUNDS  = 3,
    parameter int SCORE_W     = 4,
    localparam int PLW = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1,
    localparam int RW  = (NUM_ROUNDS > 1) ? $clog2(NUM_ROUNDS) : 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           passed,
    input  logic                           start,
    input  logic                           abort,
    input  logic                           load_in,
    input  logic                           rng_gen_in,
    input  logic                           time_out,
    input  logic                           answer_valid,
    input  logic                           answer_correct,
    output logic                           load_out,
    output logic                           rng_gen_out,
    output logic                           timer_enable,
    output logic                           timer_reconfig,
    output logic [PLW-1:0]                 active_player,
    output logic [RW-1:0]                  round_idx,
    output logic [NUM_PLAYERS*SCORE_W-1:0] scores,
    output logic                           game_over,
    output logic [PLW-1:0]                 winner
);
    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_RECONFIG   = 3'd1,
        S_WAIT_START = 3'd2,
        S_PLAY       = 3'd3,
        S_TURN_END   = 3'd4,
        S_GAME_OVER  = 3'd5
    } state_t;

    state_t                            state_q, state_d;
    logic                              load_d, rng_d, ten_d, trc_d, go_d;
    logic [PLW-1:0]                    ap_d, win_d, winner_c;
    logic [RW-1:0]                     rd_d;
    logic                              score_clr, score_inc;
    logic [NUM_PLAYERS-1:0][SCORE_W-1:0] score_q;

    wire last_player = (active_player == PLW'(NUM_PLAYERS - 1));
    wire last_round  = (round_idx == RW'(NUM_ROUNDS - 1));

    // Per-player score slots; only the active player's slot can count up.
    for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_slot
        mrgc_score_slot #(.SCORE_W(SCORE_W)) u_slot (
            .clk   (clk),
            .rst   (rst),
            .clr   (score_clr),
            .inc   (score_inc && (active_player == PLW'(p))),
            .score (score_q[p])
        );
        assign scores[p*SCORE_W +: SCORE_W] = score_q[p];
    end

    // Strict '>' keeps the lowest index on a tie.
    always_comb begin
        int best;
        best = 0;
        for (int p = 1; p < NUM_PLAYERS; p++)
            if (score_q[p] > score_q[best]) best = p;
        winner_c = PLW'(best);
    end

    always_comb begin
        logic go_idle;
        state_d   = state_q;
        load_d    = load_out;
        rng_d     = rng_gen_out;
        ten_d     = timer_enable;
        trc_d     = 1'b0;
        ap_d      = active_player;
        rd_d      = round_idx;
        go_d      = game_over;
        win_d     = winner;
        score_clr = 1'b0;
        score_inc = 1'b0;
        go_idle   = 1'b0;

        case (state_q)
            S_IDLE: begin
                go_idle = 1'b1;
                if (passed) begin
                    state_d = S_RECONFIG;
                    trc_d   = 1'b1;
                end
            end
            S_RECONFIG: state_d = S_WAIT_START;
            S_WAIT_START: begin
                if (start) begin
                    ten_d   = 1'b1;
                    state_d = S_PLAY;
                end
            end
            S_PLAY: begin
                load_d = load_in;
                rng_d  = rng_gen_in;
                // A submitted answer wins over a same-cycle timeout.
                if (answer_valid || time_out) begin
                    score_inc = answer_valid && answer_correct;
                    state_d   = S_TURN_END;
                    ten_d     = 1'b0;
                    load_d    = 1'b0;
                    rng_d     = 1'b1;
                end
            end
            S_TURN_END: begin
                if (last_player && last_round) begin
                    win_d   = winner_c;
                    go_d    = 1'b1;
                    state_d = S_GAME_OVER;
                end else begin
                    trc_d   = 1'b1;
                    state_d = S_RECONFIG;
                    if (last_player) begin
                        ap_d = '0;
                        rd_d = round_idx + 1'b1;
                    end else begin
                        ap_d = active_player + 1'b1;
                    end
                end
            end
            S_GAME_OVER: begin
                if (start) begin
                    score_clr = 1'b1;
                    ap_d      = '0;
                    rd_d      = '0;
                    go_d      = 1'b0;
                    trc_d     = 1'b1;
                    state_d   = S_RECONFIG;
                end
            end
            default: begin
                go_idle = 1'b1;
                state_d = S_IDLE;
            end
        endcase

        // Abort and illegal encodings both land in IDLE with reset values.
        if (abort || (go_idle && !(state_q == S_IDLE && passed))) begin
            state_d   = S_IDLE;
            trc_d     = 1'b0;
            score_inc = 1'b0;
        end
        if (abort || go_idle) begin
            load_d    = 1'b0;
            rng_d     = 1'b1;
            ten_d     = 1'b0;
            ap_d      = '0;
            rd_d      = '0;
            go_d      = 1'b0;
            win_d     = '0;
            score_clr = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= S_IDLE;
            load_out       <= 1'b0;
            rng_gen_out    <= 1'b1;
            timer_enable   <= 1'b0;
            timer_reconfig <= 1'b0;
            active_player  <= '0;
            round_idx      <= '0;
            game_over      <= 1'b0;
            winner         <= '0;
        end else begin
            state_q        <= state_d;
            load_out       <= load_d;
            rng_gen_out    <= rng_d;
            timer_enable   <= ten_d;
            timer_reconfig <= trc_d;
            active_player  <= ap_d;
            round_idx      <= rd_d;
            game_over      <= go_d;
            winner         <= win_d;
        end
    end
endmodule

// File: tb/tb_multi_round_game_controller.sv
// Directed bench: a full 2-player/2-round game as a vector table, then
// hand sequences for async reset, timeouts, abort and score saturation
// (second instance: 1 player, 3 rounds, 1-bit score).
module tb_multi_round_game_controller;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic passed = 0, start = 0, abort = 0, load_in = 0, rng_gen_in = 0;
    logic time_out = 0, answer_valid = 0, answer_correct = 0;

    logic       lo1, rg1, te1, tr1, go1;
    logic [0:0] ap1, rd1, w1;
    logic [7:0] sc1;
    logic       lo2, rg2, te2, tr2, go2;
    logic [0:0] ap2, w2;
    logic [1:0] rd2;
    logic [0:0] sc2;

    int n_chk = 0, n_pass = 0;

    always #5 clk = ~clk;

    multi_round_game_controller #(.NUM_PLAYERS(2), .NUM_ROUNDS(2), .SCORE_W(4)) dut (
        .clk(clk), .rst(rst), .passed(passed), .start(start), .abort(abort),
        .load_in(load_in), .rng_gen_in(rng_gen_in), .time_out(time_out),
        .answer_valid(answer_valid), .answer_correct(answer_correct),
        .load_out(lo1), .rng_gen_out(rg1), .timer_enable(te1), .timer_reconfig(tr1),
        .active_player(ap1), .round_idx(rd1), .scores(sc1), .game_over(go1), .winner(w1));

    multi_round_game_controller #(.NUM_PLAYERS(1), .NUM_ROUNDS(3), .SCORE_W(1)) dut_sat (
        .clk(clk), .rst(rst), .passed(passed), .start(start), .abort(abort),
        .load_in(load_in), .rng_gen_in(rng_gen_in), .time_out(time_out),
        .answer_valid(answer_valid), .answer_correct(answer_correct),
        .load_out(lo2), .rng_gen_out(rg2), .timer_enable(te2), .timer_reconfig(tr2),
        .active_player(ap2), .round_idx(rd2), .scores(sc2), .game_over(go2), .winner(w2));

    // Input bits: {passed,start,abort,load_in,rng_gen_in,time_out,answer_valid,answer_correct}
    localparam logic [7:0] I_NONE = 8'h00, I_PASS = 8'h80, I_START = 8'h40, I_ABORT = 8'h20,
                           I_LD = 8'h10, I_RNG = 8'h08, I_TO = 8'h04, I_AV = 8'h02, I_AC = 8'h01;

    typedef struct {
        logic [7:0]  in;
        logic [15:0] exp;
    } vec_t;
    vec_t vt[22];

    function automatic logic [15:0] mk(input logic ld, rng, ten, trc, ap, rd, go, w,
                                       input logic [3:0] s0, s1);
        return {ld, rng, ten, trc, ap, rd, go, w, s0, s1};
    endfunction

    function automatic logic [15:0] act1();
        return {lo1, rg1, te1, tr1, ap1, rd1, go1, w1, sc1[3:0], sc1[7:4]};
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic cyc(input logic [7:0] in);
        @(negedge clk);
        {passed, start, abort, load_in, rng_gen_in, time_out, answer_valid, answer_correct} = in;
        @(posedge clk);
        #1;
    endtask

    // One turn starting from RECONFIG, ending in RECONFIG or GAME_OVER.
    task automatic turn(input logic [7:0] ans);
        cyc(I_NONE);
        cyc(I_START);
        cyc(ans);
        cyc(I_NONE);
    endtask

    initial begin
        vt[0]  = '{I_LD|I_AV|I_AC,           mk(0,1,0,0,0,0,0,0,0,0)};
        vt[1]  = '{I_PASS,                   mk(0,1,0,1,0,0,0,0,0,0)};
        vt[2]  = '{I_PASS,                   mk(0,1,0,0,0,0,0,0,0,0)};
        vt[3]  = '{I_LD|I_AV|I_AC|I_TO,      mk(0,1,0,0,0,0,0,0,0,0)};
        vt[4]  = '{I_START,                  mk(0,1,1,0,0,0,0,0,0,0)};
        vt[5]  = '{I_LD,                     mk(1,0,1,0,0,0,0,0,0,0)};
        vt[6]  = '{I_AV|I_AC|I_TO|I_LD|I_RNG, mk(0,1,0,0,0,0,0,0,1,0)};
        vt[7]  = '{I_AV|I_AC,                mk(0,1,0,1,1,0,0,0,1,0)};
        vt[8]  = '{I_NONE,                   mk(0,1,0,0,1,0,0,0,1,0)};
        vt[9]  = '{I_START|I_RNG,            mk(0,1,1,0,1,0,0,0,1,0)};
        vt[10] = '{I_AV|I_AC,                mk(0,1,0,0,1,0,0,0,1,1)};
        vt[11] = '{I_NONE,                   mk(0,1,0,1,0,1,0,0,1,1)};
        vt[12] = '{I_NONE,                   mk(0,1,0,0,0,1,0,0,1,1)};
        vt[13] = '{I_START,                  mk(0,1,1,0,0,1,0,0,1,1)};
        vt[14] = '{I_AV|I_AC,                mk(0,1,0,0,0,1,0,0,2,1)};
        vt[15] = '{I_NONE,                   mk(0,1,0,1,1,1,0,0,2,1)};
        vt[16] = '{I_NONE,                   mk(0,1,0,0,1,1,0,0,2,1)};
        vt[17] = '{I_START,                  mk(0,1,1,0,1,1,0,0,2,1)};
        vt[18] = '{I_AV|I_AC,                mk(0,1,0,0,1,1,0,0,2,2)};
        vt[19] = '{I_NONE,                   mk(0,1,0,0,1,1,1,0,2,2)};
        vt[20] = '{I_AV|I_AC,                mk(0,1,0,0,1,1,1,0,2,2)};
        vt[21] = '{I_START,                  mk(0,1,0,1,0,0,0,0,0,0)};

        repeat (2) @(posedge clk);
        #1;
        chk("reset_state", act1(), mk(0,1,0,0,0,0,0,0,0,0));
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 22; i++) begin
            cyc(vt[i].in);
            chk($sformatf("vec%0d", i), act1(), vt[i].exp);
        end

        // Build P0 score 2, then hit async reset while P1 is playing.
        turn(I_AV|I_AC);
        turn(I_AV);
        turn(I_AV|I_AC);
        cyc(I_NONE);
        cyc(I_START);
        chk("play_p1_s0_2", act1(), mk(0,1,1,0,1,1,0,0,2,0));
        @(negedge clk);
        #2 rst = 1'b1;
        #1 chk("async_reset", act1(), mk(0,1,0,0,0,0,0,0,0,0));
        {passed, start, abort, load_in, rng_gen_in, time_out, answer_valid, answer_correct} = I_NONE;
        @(negedge clk);
        rst = 1'b0;
        cyc(I_NONE);
        chk("idle_after_rst", act1(), mk(0,1,0,0,0,0,0,0,0,0));
        cyc(I_PASS);
        chk("reconfig_after_rst", act1(), mk(0,1,0,1,0,0,0,0,0,0));

        // P0 times out twice, P1 correct twice.
        turn(I_TO);
        turn(I_AV|I_AC);
        turn(I_TO);
        turn(I_AV|I_AC);
        chk("p1_wins", act1(), mk(0,1,0,0,1,1,1,1,0,2));

        // Restart, reach WAIT_START of round 1, abort.
        cyc(I_START);
        chk("restart", {tr1, go1, ap1, rd1, sc1}, {1'b1, 1'b0, 1'b0, 1'b0, 8'h00});
        turn(I_AV|I_AC);
        turn(I_TO);
        cyc(I_NONE);
        chk("wait_round1", {te1, tr1, ap1, rd1, sc1}, {1'b0, 1'b0, 1'b0, 1'b1, 8'h01});
        cyc(I_ABORT|I_START);
        chk("abort_wait", act1(), mk(0,1,0,0,0,0,0,0,0,0));
        cyc(I_PASS);
        chk("pass_after_abort", act1(), mk(0,1,0,1,0,0,0,0,0,0));
        cyc(I_NONE);
        cyc(I_START);
        cyc(I_ABORT|I_AV|I_AC);
        chk("abort_over_answer", act1(), mk(0,1,0,0,0,0,0,0,0,0));

        // Saturation on the 1-player, 3-round, 1-bit-score instance.
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        cyc(I_PASS);
        turn(I_AV|I_AC);
        chk("sat_t1", {12'h0, rd2, sc2, go2, tr2}, {12'h0, 2'd1, 1'b1, 1'b0, 1'b1});
        turn(I_AV|I_AC);
        chk("sat_t2", {12'h0, rd2, sc2, go2, tr2}, {12'h0, 2'd2, 1'b1, 1'b0, 1'b1});
        turn(I_AV|I_AC);
        chk("sat_t3", {11'h0, rd2, sc2, go2, tr2, w2}, {11'h0, 2'd2, 1'b1, 1'b1, 1'b0, 1'b0});

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
